// File: rtl/button_conditioner_if.sv
// Button bundle between the raw board pins and the conditioned outputs.
// The master drives the raw pin levels; the slave (the conditioner)
// returns the debounced level and the press/release pulses.
interface button_conditioner_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] btn_raw;
  logic [WIDTH-1:0] btn_level;
  logic [WIDTH-1:0] btn_press;
  logic [WIDTH-1:0] btn_release;

  modport master (
    output btn_raw,
    input  btn_level,
    input  btn_press,
    input  btn_release
  );

  modport slave (
    input  btn_raw,
    output btn_level,
    output btn_press,
    output btn_release
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button conditioner: per channel a 2-flop synchronizer, a debounce
// counter that accepts a new level only after it has persisted DEBOUNCE
// cycles, and registered one-cycle press/release pulses.
// Optional feature macro: BUTTON_CONDITIONER_REPEAT_EN adds per-channel hold
// counters that re-pulse btn_press after REPEAT_DELAY cycles of holding and
// then every REPEAT_PERIOD cycles until release.
module button_conditioner #(
  parameter int WIDTH         = 3,
  parameter int DEBOUNCE      = 50000,
  parameter int CNT_BITS      = 16,
  parameter int ACTIVE_LOW    = 1,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000
) (
  input  logic                 clock,
  input  logic                 reset,
  button_conditioner_if.slave  btn
);

  // Raw level the pins show while the button is released.
  localparam logic REL_LEVEL = (ACTIVE_LOW != 0);
  localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(DEBOUNCE - 1);

  // Elaboration-time sanity checks on the configuration.
  if (DEBOUNCE < 1 || DEBOUNCE > (2 ** CNT_BITS)) begin : g_bad_debounce
    $error("button_conditioner: DEBOUNCE out of range for CNT_BITS");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("button_conditioner: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic [WIDTH-1:0]    sync1_q;
  logic [WIDTH-1:0]    sync2_q;
  logic [WIDTH-1:0]    pressed_w;
  logic [WIDTH-1:0]    accept_w;
  logic [CNT_BITS-1:0] cnt_q [WIDTH];
  logic [CNT_BITS-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0]    level_q, level_d;
  logic [WIDTH-1:0]    press_q, press_d;
  logic [WIDTH-1:0]    release_q, release_d;

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  localparam int HOLD_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int HOLD_BITS = $clog2(HOLD_MAX + 1);
  localparam logic [HOLD_BITS-1:0] DELAY_LAST  = HOLD_BITS'(REPEAT_DELAY - 1);
  localparam logic [HOLD_BITS-1:0] PERIOD_LAST = HOLD_BITS'(REPEAT_PERIOD - 1);

  logic [HOLD_BITS-1:0] hold_q [WIDTH];
  logic [HOLD_BITS-1:0] hold_d [WIDTH];
  // Set once the first (delay) repeat has fired; later repeats use the period.
  logic [WIDTH-1:0]     rpt_q, rpt_d;
`endif

  // Polarity is applied after the synchronizer so the raw pin only ever
  // feeds the first flop.
  assign pressed_w = sync2_q ^ {WIDTH{REL_LEVEL}};

  // A channel accepts its new level on the edge where the count completes.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      accept_w[i] = (pressed_w[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
    end
  end

  // Two-flop synchronizer; resets to the released pin level so leaving
  // reset never looks like an edge.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= {WIDTH{REL_LEVEL}};
      sync2_q <= {WIDTH{REL_LEVEL}};
    end else begin
      sync1_q <= btn.btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Next-state for the debounce counters, accepted levels and pulses.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (pressed_w[i] == level_q[i]) begin
        // Agreement (or a bounce back) discards any partial count.
        cnt_d[i] = '0;
      end else if (accept_w[i]) begin
        level_d[i]   = pressed_w[i];
        cnt_d[i]     = '0;
        press_d[i]   = pressed_w[i];
        release_d[i] = ~pressed_w[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
      end
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      hold_d[i] = hold_q[i];
      rpt_d[i]  = rpt_q[i];
      if (!level_q[i] || accept_w[i]) begin
        // Not held, or the release is being accepted now: no repeat, and the
        // release edge takes priority so press/release never coincide.
        hold_d[i] = '0;
        rpt_d[i]  = 1'b0;
      end else if (!rpt_q[i] && hold_q[i] == DELAY_LAST) begin
        press_d[i] = 1'b1;
        hold_d[i]  = '0;
        rpt_d[i]   = 1'b1;
      end else if (rpt_q[i] && hold_q[i] == PERIOD_LAST) begin
        press_d[i] = 1'b1;
        hold_d[i]  = '0;
      end else begin
        hold_d[i] = hold_q[i] + HOLD_BITS'(1);
      end
`endif
    end
  end

  // State and registered outputs; reset drops any debounce in progress.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

`ifdef BUTTON_CONDITIONER_REPEAT_EN
  // Hold counters for auto-repeat.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_q[i] <= '0;
      end
      rpt_q <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        hold_q[i] <= hold_d[i];
      end
      rpt_q <= rpt_d;
    end
  end
`endif

  assign btn.btn_level   = level_q;
  assign btn.btn_press   = press_q;
  assign btn.btn_release = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: an ACTIVE_LOW=1 and an ACTIVE_LOW=0 instance,
// DEBOUNCE=4. Stimulus pushes expected pulse events into per-instance queues;
// monitors pop and compare whenever a DUT shows a press or release pulse.
module tb_button_conditioner;

  localparam int W  = 3;
  localparam int DB = 4;
  // Edges from the drive point (just after edge c) to the output change:
  // first sample at c+1, change at (c+1)+1+DB.
  localparam int LAT = DB + 2;

  typedef struct {
    int         cyc;
    logic [2:0] pr;
    logic [2:0] rl;
    logic [2:0] lv;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  ev_t  q0[$];
  ev_t  q1[$];

  button_conditioner_if #(.WIDTH(W)) bus0 ();
  button_conditioner_if #(.WIDTH(W)) bus1 ();

  button_conditioner #(
    .WIDTH(W), .DEBOUNCE(DB), .CNT_BITS(4), .ACTIVE_LOW(1),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut0 (
    .clock(clk), .reset(rst), .btn(bus0.slave)
  );

  button_conditioner #(
    .WIDTH(W), .DEBOUNCE(DB), .CNT_BITS(4), .ACTIVE_LOW(0),
    .REPEAT_DELAY(20), .REPEAT_PERIOD(8)
  ) dut1 (
    .clock(clk), .reset(rst), .btn(bus1.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic exp0(input int at, input logic [2:0] pr, input logic [2:0] rl, input logic [2:0] lv);
    ev_t e;
    e.cyc = at; e.pr = pr; e.rl = rl; e.lv = lv;
    q0.push_back(e);
  endtask

  task automatic exp1(input int at, input logic [2:0] pr, input logic [2:0] rl, input logic [2:0] lv);
    ev_t e;
    e.cyc = at; e.pr = pr; e.rl = rl; e.lv = lv;
    q1.push_back(e);
  endtask

  task automatic check3(input string name, input logic [2:0] got, input logic [2:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %b, want %b (cyc %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor for the active-low instance.
  always @(negedge clk) begin
    if (!rst && (bus0.btn_press != 0 || bus0.btn_release != 0)) begin
      tests++;
      if (q0.size() == 0) begin
        fails++;
        $display("FAIL dut0_unexpected: cyc=%0d press=%b rel=%b lvl=%b, want no pulse",
                 cyc, bus0.btn_press, bus0.btn_release, bus0.btn_level);
      end else begin
        ev_t e;
        e = q0.pop_front();
        if (cyc != e.cyc || bus0.btn_press !== e.pr || bus0.btn_release !== e.rl ||
            bus0.btn_level !== e.lv) begin
          fails++;
          $display("FAIL dut0_event: got cyc=%0d press=%b rel=%b lvl=%b, want cyc=%0d press=%b rel=%b lvl=%b",
                   cyc, bus0.btn_press, bus0.btn_release, bus0.btn_level, e.cyc, e.pr, e.rl, e.lv);
        end
      end
    end
  end

  // Monitor for the active-high instance.
  always @(negedge clk) begin
    if (!rst && (bus1.btn_press != 0 || bus1.btn_release != 0)) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL dut1_unexpected: cyc=%0d press=%b rel=%b lvl=%b, want no pulse",
                 cyc, bus1.btn_press, bus1.btn_release, bus1.btn_level);
      end else begin
        ev_t e;
        e = q1.pop_front();
        if (cyc != e.cyc || bus1.btn_press !== e.pr || bus1.btn_release !== e.rl ||
            bus1.btn_level !== e.lv) begin
          fails++;
          $display("FAIL dut1_event: got cyc=%0d press=%b rel=%b lvl=%b, want cyc=%0d press=%b rel=%b lvl=%b",
                   cyc, bus1.btn_press, bus1.btn_release, bus1.btn_level, e.cyc, e.pr, e.rl, e.lv);
        end
      end
    end
  end

  initial begin
    bus0.btn_raw = 3'b111;
    bus1.btn_raw = 3'b000;
    rst = 1'b1;

    // Reset then idle.
    step(3);
    check3("reset_level", bus0.btn_level, 3'b000);
    check3("reset_press", bus0.btn_press, 3'b000);
    rst = 1'b0;
    step(20);
    check3("idle_level", bus0.btn_level, 3'b000);
    check3("idle_level_ah", bus1.btn_level, 3'b000);

    // Clean press and release on channel 0.
    bus0.btn_raw[0] = 1'b0;
    exp0(cyc + LAT, 3'b001, 3'b000, 3'b001);
    step(10);
    check3("press_level", bus0.btn_level, 3'b001);
    bus0.btn_raw[0] = 1'b1;
    exp0(cyc + LAT, 3'b000, 3'b001, 3'b000);
    step(10);

    // Bouncing channel 1: only the final settled low is accepted.
    bus0.btn_raw[1] = 1'b0; step(2);
    bus0.btn_raw[1] = 1'b1; step(2);
    bus0.btn_raw[1] = 1'b0; step(2);
    bus0.btn_raw[1] = 1'b1; step(2);
    bus0.btn_raw[1] = 1'b0;
    exp0(cyc + LAT, 3'b010, 3'b000, 3'b010);
    step(10);
    bus0.btn_raw[1] = 1'b1;
    exp0(cyc + LAT, 3'b000, 3'b010, 3'b000);
    step(10);

    // All channels pressed on one edge.
    bus0.btn_raw = 3'b000;
    exp0(cyc + LAT, 3'b111, 3'b000, 3'b111);
    step(10);
    check3("simul_level", bus0.btn_level, 3'b111);

    // Release, then reset part-way through its debounce.
    bus0.btn_raw = 3'b111;
    step(3);
    rst = 1'b1;
    #1;
    check3("async_rst_level", bus0.btn_level, 3'b000);
    check3("async_rst_rel", bus0.btn_release, 3'b000);
    step(2);
    rst = 1'b0;
    step(15);
    check3("post_rst_level", bus0.btn_level, 3'b000);

    // Active-high instance: press held, then released.
    bus1.btn_raw[0] = 1'b1;
    exp1(cyc + LAT, 3'b001, 3'b000, 3'b001);
    step(10);
    check3("ah_level", bus1.btn_level, 3'b001);
    bus1.btn_raw[0] = 1'b0;
    exp1(cyc + LAT, 3'b000, 3'b001, 3'b000);
    step(10);

    // Long hold on channel 2: repeats only when the feature is built.
    begin
      int acc;
      bus0.btn_raw[2] = 1'b0;
      acc = cyc + LAT;
      exp0(acc, 3'b100, 3'b000, 3'b100);
`ifdef BUTTON_CONDITIONER_REPEAT_EN
      exp0(acc + 20, 3'b100, 3'b000, 3'b100);
      exp0(acc + 28, 3'b100, 3'b000, 3'b100);
      exp0(acc + 36, 3'b100, 3'b000, 3'b100);
      exp0(acc + 44, 3'b100, 3'b000, 3'b100);
      exp0(acc + 52, 3'b100, 3'b000, 3'b100);
`endif
      step(56);
      check3("hold_level", bus0.btn_level, 3'b100);
      bus0.btn_raw[2] = 1'b1;
      exp0(cyc + LAT, 3'b000, 3'b100, 3'b000);
      step(20);
    end

    // Every expected event must have been seen by now.
    tests++;
    if (q0.size() != 0) begin
      fails++;
      $display("FAIL dut0_pending: %0d events left, want 0 (next due cyc %0d)", q0.size(), q0[0].cyc);
    end
    tests++;
    if (q1.size() != 0) begin
      fails++;
      $display("FAIL dut1_pending: %0d events left, want 0 (next due cyc %0d)", q1.size(), q1[0].cyc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
